// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two async read ports, one sync write port, optional R0=0,
// optional write->read bypass, and a one-entry-per-cycle clear sweep.
//
// Ports:
//   clk, clr_n (async active-low) ; clr_start requests a new clear sweep
//   wr_en / w_addr / w_data       : synchronous write port
//   ra_addr/ra_data, rb_addr/rb_data : combinational read ports
//   busy    : sweep in progress, writes rejected, reads return 0
//   done    : one-cycle pulse on the first idle cycle after a sweep
//   wr_drop : one-cycle pulse the cycle after a rejected write
module reg_file_2r1w #(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 32,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clr_start,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic [DEPTH-1:0] ra_addr,
    input  logic [DEPTH-1:0] rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic             busy,
    output logic             done,
    output logic             wr_drop
);

    localparam int N = 1 << DEPTH;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [DEPTH-1:0] ptr, ptr_nx;
    logic             done_nx;
    logic             drop_nx;

    logic             we;
    logic [DEPTH-1:0] wa;
    logic [WIDTH-1:0] wd;

    logic [WIDTH-1:0] mem [N];

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        done_nx  = 1'b0;
        drop_nx  = 1'b0;
        we       = 1'b0;
        wa       = w_addr;
        wd       = w_data;
        unique case (state)
            CLEAR: begin
                // The sweep owns the write port; any user write is lost.
                we      = 1'b1;
                wa      = ptr;
                wd      = '0;
                drop_nx = wr_en;
                ptr_nx  = ptr + 1'b1;
                if (ptr == {DEPTH{1'b1}}) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    ptr_nx   = '0;
                end
            end
            IDLE: begin
                if (clr_start) begin
                    state_nx = CLEAR;
                    ptr_nx   = '0;
                    drop_nx  = wr_en;
                end else if (wr_en &&
                             !(ZERO_R0 && (w_addr == '0))) begin
                    we = 1'b1;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= CLEAR;
            ptr     <= '0;
            done    <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            done    <= done_nx;
            wr_drop <= drop_nx;
        end
    end

    // Storage has no reset; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign busy = (state == CLEAR);

    // Bypass is only taken when the file is idle and a write is offered.
    logic byp_ok;
    assign byp_ok = BYPASS && !busy && wr_en;

    always_comb begin
        ra_data = mem[ra_addr];
        if (busy) begin
            ra_data = '0;
        end else if (ZERO_R0 && (ra_addr == '0)) begin
            ra_data = '0;
        end else if (byp_ok && (ra_addr == w_addr)) begin
            ra_data = w_data;
        end
    end

    always_comb begin
        rb_data = mem[rb_addr];
        if (busy) begin
            rb_data = '0;
        end else if (ZERO_R0 && (rb_addr == '0)) begin
            rb_data = '0;
        end else if (byp_ok && (rb_addr == w_addr)) begin
            rb_data = w_data;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed test of reg_file_2r1w.
// u_dut uses ZERO_R0=1/BYPASS=1, u_alt uses ZERO_R0=0/BYPASS=0.
module tb_reg_file_2r1w;

    logic        clk;
    logic        clr_n;
    logic        clr_start;
    logic        wr_en;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;

    logic [31:0] ra_data, rb_data;
    logic        busy, done, wr_drop;
    logic [31:0] ra_alt, rb_alt;
    logic        busy_alt, done_alt, drop_alt;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    reg_file_2r1w #(
        .DEPTH(4), .WIDTH(32), .ZERO_R0(1'b1), .BYPASS(1'b1)
    ) u_dut (
        .clk(clk), .clr_n(clr_n), .clr_start(clr_start),
        .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data),
        .busy(busy), .done(done), .wr_drop(wr_drop)
    );

    reg_file_2r1w #(
        .DEPTH(4), .WIDTH(32), .ZERO_R0(1'b0), .BYPASS(1'b0)
    ) u_alt (
        .clk(clk), .clr_n(clr_n), .clr_start(clr_start),
        .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_alt), .rb_data(rb_alt),
        .busy(busy_alt), .done(done_alt), .wr_drop(drop_alt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_seen++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en  = 1'b1;
        w_addr = a;
        w_data = d;
        tick();
        wr_en  = 1'b0;
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    int cnt;
    int zero_bad;
    int drops;

    initial begin
        clr_n     = 1'b0;
        clr_start = 1'b0;
        wr_en     = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        ra_addr   = 4'd5;
        rb_addr   = 4'd5;

        // reset held for 3 cycles
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_drop", 32'(wr_drop), 32'd0);
        chk("rst_ra", ra_data, 32'd0);

        clr_n = 1'b1;
        wait_idle(cnt);
        chk("sweep_len", 32'(cnt), 32'd16);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd1);
        chk("alt_done", 32'(done_alt), 32'd1);
        chk("cleared_r5", ra_data, 32'd0);
        chk("alt_cleared_r5", ra_alt, 32'd0);
        tick();
        chk("done_pulse", 32'(done), 32'd0);

        // dual read
        wr(4'd3, 32'hDEADBEEF);
        wr(4'd7, 32'h12345678);
        ra_addr = 4'd3;
        rb_addr = 4'd7;
        #1;
        chk("dual_ra", ra_data, 32'hDEADBEEF);
        chk("dual_rb", rb_data, 32'h12345678);
        chk("alt_dual_ra", ra_alt, 32'hDEADBEEF);
        chk("alt_dual_rb", rb_alt, 32'h12345678);
        rb_addr = 4'd3;
        #1;
        chk("same_addr_rb", rb_data, 32'hDEADBEEF);

        // bypass
        wr(4'd4, 32'h11110000);
        ra_addr = 4'd4;
        rb_addr = 4'd4;
        wr_en   = 1'b1;
        w_addr  = 4'd4;
        w_data  = 32'hA5A5A5A5;
        #1;
        chk("byp_ra", ra_data, 32'hA5A5A5A5);
        chk("byp_rb", rb_data, 32'hA5A5A5A5);
        chk("nobyp_old", ra_alt, 32'h11110000);
        tick();
        wr_en = 1'b0;
        #1;
        chk("nobyp_new", ra_alt, 32'hA5A5A5A5);
        chk("byp_stored", ra_data, 32'hA5A5A5A5);

        // R0
        ra_addr = 4'd0;
        wr_en   = 1'b1;
        w_addr  = 4'd0;
        w_data  = 32'hFFFFFFFF;
        #1;
        chk("r0_byp", ra_data, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("r0_read", ra_data, 32'd0);
        chk("r0_nodrop", 32'(wr_drop), 32'd0);
        chk("alt_r0", ra_alt, 32'hFFFFFFFF);

        // clear with colliding write, plus a write mid-sweep
        wr(4'd9, 32'h55);
        ra_addr = 4'd9;
        rb_addr = 4'd2;
        #1;
        chk("r9_pre", ra_data, 32'h55);
        clr_start = 1'b1;
        wr_en     = 1'b1;
        w_addr    = 4'd9;
        w_data    = 32'h77;
        tick();
        clr_start = 1'b0;
        wr_en     = 1'b0;
        #1;
        chk("col_drop", 32'(wr_drop), 32'd1);
        chk("col_busy", 32'(busy), 32'd1);
        chk("alt_col_drop", 32'(drop_alt), 32'd1);
        cnt      = 0;
        zero_bad = 0;
        drops    = 0;
        while (busy && cnt < 40) begin
            if (ra_data !== 32'd0 || rb_data !== 32'd0) zero_bad++;
            if (wr_drop) drops++;
            cnt++;
            wr_en  = (cnt == 4);
            w_addr = 4'd2;
            w_data = 32'h99;
            tick();
        end
        wr_en = 1'b0;
        #1;
        chk("clr_len", 32'(cnt), 32'd16);
        chk("clr_reads0", 32'(zero_bad), 32'd0);
        chk("clr_drops", 32'(drops), 32'd2);
        chk("clr_done", 32'(done), 32'd1);
        chk("r9_after", ra_data, 32'd0);
        chk("r2_after", rb_data, 32'd0);

        // reset mid-sweep
        wr(4'd5, 32'hABCD);
        ra_addr   = 4'd5;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (8) tick();
        done_seen = 0;
        clr_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        repeat (2) tick();
        clr_n = 1'b1;
        wait_idle(cnt);
        chk("restart_len", 32'(cnt), 32'd16);
        chk("restart_done", 32'(done), 32'd1);
        chk("r5_after", ra_data, 32'd0);
        repeat (3) tick();
        chk("done_once", 32'(done_seen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
